// File: rtl/xxh32_stripe_packer.sv
// xxh32_stripe_packer: packs 32-bit little-endian message words into
// 128-bit xxh32 stripes and tags the final stripe with word/byte counts.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     word handshake; in_data byte 0 in [7:0]
//   in_last, in_bytes     final word flag and its valid bytes (0..4)
//   out_valid/out_ready   stripe handshake
//   out_stripe            word 0 in [31:0] .. word 3 in [127:96]
//   out_nwords            valid words in stripe (0..4)
//   out_last_bytes        valid bytes in highest valid word (0..4)
//   out_last              final stripe of the message
//   out_total_len         message byte length, valid with out_last
//
// Optional: define XXH_PACKER_STATS_EN to add stat_stripes, stat_msgs
// and stat_stalls saturating counters.
module xxh32_stripe_packer #(
    parameter int LEN_W = 32,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_bytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_stripe,
    output logic [2:0]       out_nwords,
    output logic [2:0]       out_last_bytes,
    output logic             out_last,
    output logic [LEN_W-1:0] out_total_len
`ifdef XXH_PACKER_STATS_EN
    ,
    output logic [31:0]      stat_stripes,
    output logic [31:0]      stat_msgs,
    output logic [31:0]      stat_stalls
`endif
);

    logic [1:0]             cnt_q, cnt_d;
    logic [LANES-1:0][31:0] buf_q, buf_d;
    logic [LEN_W-1:0]       len_q, len_d;

    logic                   out_valid_q, out_valid_d;
    logic [127:0]           out_stripe_q, out_stripe_d;
    logic [2:0]             out_nwords_q, out_nwords_d;
    logic [2:0]             out_last_bytes_q, out_last_bytes_d;
    logic                   out_last_q, out_last_d;
    logic [LEN_W-1:0]       out_total_len_q, out_total_len_d;

    logic [2:0]             eff_bytes;
    logic [31:0]            data_m;
    logic                   acc;
    logic                   done;
    logic                   store;
    logic [LEN_W-1:0]       len_sum;
    logic [LANES-1:0][31:0] stripe_next;

    // Only the last word carries a byte count; anything above 4 clamps.
    assign eff_bytes = !in_last         ? 3'd4 :
                       (in_bytes > 3'd4) ? 3'd4 : in_bytes;

    always_comb begin
        data_m = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < eff_bytes) begin
                data_m[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    // A word that cannot close a stripe never waits on the output side.
    assign in_ready = ((cnt_q != 2'd3) && !in_last) ||
                      !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign done     = acc && ((cnt_q == 2'd3) || in_last);
    assign store    = (eff_bytes != 3'd0);
    assign len_sum  = len_q + LEN_W'(eff_bytes);

    always_comb begin
        stripe_next = buf_q;
        if (store) begin
            stripe_next[cnt_q] = data_m;
        end
    end

    always_comb begin
        cnt_d            = cnt_q;
        buf_d            = buf_q;
        len_d            = len_q;
        out_valid_d      = out_valid_q;
        out_stripe_d     = out_stripe_q;
        out_nwords_d     = out_nwords_q;
        out_last_bytes_d = out_last_bytes_q;
        out_last_d       = out_last_q;
        out_total_len_d  = out_total_len_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done) begin
            out_valid_d     = 1'b1;
            out_stripe_d    = stripe_next;
            out_nwords_d    = {1'b0, cnt_q} + {2'b00, store};
            // An empty closing word leaves the last held word, if any, full.
            out_last_bytes_d = store            ? eff_bytes :
                               (cnt_q == 2'd0)  ? 3'd0 : 3'd4;
            out_last_d      = in_last;
            out_total_len_d = len_sum;
            cnt_d           = 2'd0;
            buf_d           = '0;
            len_d           = in_last ? '0 : len_sum;
        end else if (acc) begin
            cnt_d = cnt_q + 2'd1;
            buf_d = stripe_next;
            len_d = len_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q            <= '0;
            buf_q            <= '0;
            len_q            <= '0;
            out_valid_q      <= 1'b0;
            out_stripe_q     <= '0;
            out_nwords_q     <= '0;
            out_last_bytes_q <= '0;
            out_last_q       <= 1'b0;
            out_total_len_q  <= '0;
        end else begin
            cnt_q            <= cnt_d;
            buf_q            <= buf_d;
            len_q            <= len_d;
            out_valid_q      <= out_valid_d;
            out_stripe_q     <= out_stripe_d;
            out_nwords_q     <= out_nwords_d;
            out_last_bytes_q <= out_last_bytes_d;
            out_last_q       <= out_last_d;
            out_total_len_q  <= out_total_len_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_stripe     = out_stripe_q;
    assign out_nwords     = out_nwords_q;
    assign out_last_bytes = out_last_bytes_q;
    assign out_last       = out_last_q;
    assign out_total_len  = out_total_len_q;

`ifdef XXH_PACKER_STATS_EN
    logic [31:0] stripes_q, stripes_d;
    logic [31:0] msgs_q, msgs_d;
    logic [31:0] stalls_q, stalls_d;
    logic        xfer;

    assign xfer = out_valid_q && out_ready;

    always_comb begin
        stripes_d = stripes_q;
        msgs_d    = msgs_q;
        stalls_d  = stalls_q;
        if (xfer && !(&stripes_q)) begin
            stripes_d = stripes_q + 32'd1;
        end
        if (xfer && out_last_q && !(&msgs_q)) begin
            msgs_d = msgs_q + 32'd1;
        end
        if (in_valid && !in_ready && !(&stalls_q)) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stripes_q <= '0;
            msgs_q    <= '0;
            stalls_q  <= '0;
        end else begin
            stripes_q <= stripes_d;
            msgs_q    <= msgs_d;
            stalls_q  <= stalls_d;
        end
    end

    assign stat_stripes = stripes_q;
    assign stat_msgs    = msgs_q;
    assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_xxh32_stripe_packer.sv
// tb_xxh32_stripe_packer: self-checking bench for xxh32_stripe_packer.
// Stripes are predicted from the message words with plain arithmetic.
module tb_xxh32_stripe_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_stripe;
    logic [2:0]   out_nwords;
    logic [2:0]   out_last_bytes;
    logic         out_last;
    logic [31:0]  out_total_len;
`ifdef XXH_PACKER_STATS_EN
    logic [31:0]  stat_stripes, stat_msgs, stat_stalls;
`endif

    xxh32_stripe_packer #(.LEN_W(32), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_stripe(out_stripe), .out_nwords(out_nwords),
        .out_last_bytes(out_last_bytes), .out_last(out_last),
        .out_total_len(out_total_len)
`ifdef XXH_PACKER_STATS_EN
        , .stat_stripes(stat_stripes), .stat_msgs(stat_msgs),
        .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] s;
        logic [2:0]   nw;
        logic [2:0]   lb;
        logic         last;
        logic [31:0]  tot;
    } st_t;

    st_t         rx[$];
    st_t         ex[$];
    logic [31:0] msg[$];
    int          wstall[$];
    int          stall_seen = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rnd_on = 0;

    // Monitor: outputs and handshakes are stable between negedge+2 and posedge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            rx.push_back('{out_stripe, out_nwords, out_last_bytes,
                           out_last, out_total_len});
        end
        if (rst_n && in_valid && !in_ready) stall_seen++;
    end

    function automatic void model(input int b);
        int   n, eb, ns, base, cnt;
        logic [31:0] m;
        st_t  e;
        n  = msg.size();
        eb = (b > 4) ? 4 : b;
        ns = (n - 1) / 4 + 1;
        for (int k = 0; k < ns; k++) begin
            e = '{default: '0};
            base = 4 * k;
            if (k < ns - 1) begin
                for (int j = 0; j < 4; j++) e.s[32*j +: 32] = msg[base+j];
                e.nw = 3'd4;
                e.lb = 3'd4;
            end else begin
                cnt = n - 1 - base;
                for (int j = 0; j < cnt; j++) e.s[32*j +: 32] = msg[base+j];
                if (eb > 0) begin
                    m = (eb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * eb)) - 1);
                    e.s[32*cnt +: 32] = msg[n-1] & m;
                    e.nw = 3'(cnt + 1);
                    e.lb = 3'(eb);
                end else begin
                    e.nw = 3'(cnt);
                    e.lb = (cnt == 0) ? 3'd0 : 3'd4;
                end
                e.last = 1'b1;
                e.tot  = 32'(4 * (n - 1) + eb);
            end
            ex.push_back(e);
        end
    endfunction

    function automatic bit same(input st_t a, input st_t e);
        return (a.s === e.s) && (a.nw === e.nw) && (a.lb === e.lb) &&
               (a.last === e.last) && (!e.last || (a.tot === e.tot));
    endfunction

    // Entered and left at a negedge.
    task automatic send_word(input logic [31:0] d, input bit last,
                             input logic [2:0] nb);
        int st = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        #1;
        while (!in_ready && st < 300) begin
            st++;
            @(negedge clk);
            #1;
        end
        if (st >= 300) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        wstall.push_back(st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_msg(input int b, input bit do_last, input bit gaps);
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            if (do_last && i == msg.size() - 1)
                send_word(msg[i], 1'b1, 3'(b));
            else
                send_word(msg[i], 1'b0, 3'($urandom_range(0, 7)));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int cyc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (rx.size() < ex.size() && cyc < 500) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        repeat (4) @(negedge clk);
        ok = (rx.size() == ex.size());
    endtask

    task automatic clear_q();
        rx.delete();
        ex.delete();
        msg.delete();
        wstall.delete();
    endtask

    task automatic compare_all(input string name);
        bit ok;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_count: got %0d stripes required %0d",
                     name, rx.size(), ex.size());
        end
        for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
            checks++;
            if (!same(rx[k], ex[k])) begin
                errors++;
                $display("FAIL %s_stripe%0d: got %h nw=%0d lb=%0d last=%0b len=%0d required %h nw=%0d lb=%0d last=%0b len=%0d",
                         name, k, rx[k].s, rx[k].nw, rx[k].lb, rx[k].last,
                         rx[k].tot, ex[k].s, ex[k].nw, ex[k].lb, ex[k].last,
                         ex[k].tot);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        stall_seen = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_stripe !== '0) begin
            errors++;
            $display("FAIL reset_valid_stripe: got %0b %h required 0 0",
                     out_valid, out_stripe);
        end
        checks++;
        if (out_nwords !== 3'd0 || out_last_bytes !== 3'd0 ||
            out_last !== 1'b0 || out_total_len !== 32'd0) begin
            errors++;
            $display("FAIL reset_fields: got nw=%0d lb=%0d last=%0b len=%0d required 0",
                     out_nwords, out_last_bytes, out_last, out_total_len);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_seq16();
        int st = 0;
        clear_q();
        for (int i = 1; i <= 16; i++) msg.push_back(32'(i));
        model(4);
        send_msg(4, 1'b1, 1'b0);
        compare_all("seq16");
        foreach (wstall[i]) st += wstall[i];
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL seq16_in_ready: got %0d stall cycles required 0", st);
        end
        checks++;
        if (rx.size() < 1 ||
            rx[0].s !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL seq16_first: got %h required %h",
                     (rx.size() > 0) ? rx[0].s : 128'h0,
                     128'h00000004_00000003_00000002_00000001);
        end
    endtask

    task automatic test_partial();
        clear_q();
        repeat (5) msg.push_back(32'hAABBCCDD);
        model(3);
        send_msg(3, 1'b1, 1'b0);
        compare_all("partial");
        checks++;
        if (rx.size() < 2 || rx[1].s !== 128'h00BBCCDD ||
            rx[1].tot !== 32'd19 || rx[1].nw !== 3'd1) begin
            errors++;
            $display("FAIL partial_tail: got %h len=%0d required %h len=19",
                     (rx.size() > 1) ? rx[1].s : 128'h0,
                     (rx.size() > 1) ? rx[1].tot : 32'h0, 128'h00BBCCDD);
        end
    endtask

    task automatic test_empty();
        clear_q();
        msg.push_back(32'hDEADBEEF);
        model(0);
        send_msg(0, 1'b1, 1'b0);
        compare_all("empty");
    endtask

    task automatic test_backpressure();
        logic [127:0] s0;
        logic [2:0]   nw0;
        int           w;
        bit           stall_ok;
        do_reset();
        clear_q();
        @(negedge clk);
        out_ready = 1'b0;
        repeat (8) msg.push_back($urandom);
        model(4);
        fork
            send_msg(4, 1'b1, 1'b0);
            begin
                w = 0;
                while (!out_valid && w < 50) begin
                    @(negedge clk);
                    #2;
                    w++;
                end
                s0  = out_stripe;
                nw0 = out_nwords;
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    checks++;
                    if (!out_valid || out_stripe !== s0 || out_nwords !== nw0) begin
                        errors++;
                        $display("FAIL bp_hold: got v=%0b %h required v=1 %h",
                                 out_valid, out_stripe, s0);
                    end
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        compare_all("bp");
        stall_ok = (wstall.size() == 8) && (wstall[7] > 0);
        for (int i = 0; i < 7 && i < wstall.size(); i++)
            if (wstall[i] != 0) stall_ok = 0;
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL bp_in_ready: got last word stalls=%0d required >0 only on word 8",
                     (wstall.size() == 8) ? wstall[7] : -1);
        end
`ifdef XXH_PACKER_STATS_EN
        checks++;
        if (stat_stripes !== 32'd2 || stat_msgs !== 32'd1 ||
            stat_stalls !== 32'(stall_seen)) begin
            errors++;
            $display("FAIL bp_stats: got %0d %0d %0d required 2 1 %0d",
                     stat_stripes, stat_msgs, stat_stalls, stall_seen);
        end
`endif
    endtask

    task automatic test_reset_mid();
        clear_q();
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) msg.push_back($urandom);
        send_msg(4, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_stripe !== '0 || out_nwords !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%0b %h nw=%0d required 0",
                     out_valid, out_stripe, out_nwords);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_q();
        repeat (4) msg.push_back($urandom);
        model(4);
        send_msg(4, 1'b1, 1'b0);
        compare_all("rstmid");
    endtask

    task automatic test_back_to_back();
        int st = 0;
        clear_q();
        for (int m = 0; m < 3; m++) begin
            int b = $urandom_range(1, 4);
            msg.delete();
            repeat (4 * m + 3) msg.push_back($urandom);
            model(b);
            send_msg(b, 1'b1, 1'b0);
        end
        compare_all("b2b");
        foreach (wstall[i]) st += wstall[i];
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d stall cycles required 0", st);
        end
    endtask

    task automatic test_random();
        clear_q();
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int m = 0; m < 20; m++) begin
            int b = $urandom_range(0, 7);
            int n = $urandom_range(1, 13);
            msg.delete();
            repeat (n) msg.push_back($urandom);
            model(b);
            send_msg(b, 1'b1, 1'b1);
        end
        rnd_on = 0;
        repeat (2) @(negedge clk);
        compare_all("random");
    endtask

    initial begin
        test_reset();
        test_seq16();
        test_partial();
        test_empty();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
